// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, canonical NOP and the fetch FSM state encoding.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register. Priority: reset > load (redirect) > sequential increment.
module pc_reg
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic            incr_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (incr_i) begin
            // Wraps modulo 2^32 by construction.
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues req/ack word reads and hands words to decode
// over valid/ready. Handles branch redirects, decode halt and misaligned-target faults.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fetch_fault
);

    fetch_state_e    state_q, state_d;
    logic            halt_pend_q, halt_pend_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] drain_addr_q, drain_addr_d;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic [XLEN-1:0] pc;
    logic            pc_load;
    logic            pc_incr;
    logic            capture;
    logic            misalign;
    logic            stop;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc),
        .incr_i    (pc_incr),
        .pc_o      (pc)
    );

    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // Any reason that ends fetching for good: decode halt or a faulting target.
    assign stop     = halt || misalign;

    always_comb begin
        state_d      = state_q;
        halt_pend_d  = halt_pend_q;
        fault_d      = fault_q;
        drain_addr_d = drain_addr_q;
        pc_load      = 1'b0;
        pc_incr      = 1'b0;
        capture      = 1'b0;

        unique case (state_q)
            S_REQ: begin
                pc_load = redirect_valid;
                if (imem_ack) begin
                    if (stop) begin
                        state_d = S_HALT;
                    end else if (redirect_valid) begin
                        state_d = S_REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (stop || redirect_valid) begin
                    // The request cannot be withdrawn; finish it at the old address.
                    state_d      = S_DRAIN;
                    drain_addr_d = pc;
                    halt_pend_d  = stop;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                end else if (instr_ready) begin
                    pc_incr = 1'b1;
                end
                if (stop) begin
                    state_d = S_HALT;
                end else if (redirect_valid || instr_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                pc_load = redirect_valid;
                if (stop) begin
                    halt_pend_d = 1'b1;
                end
                if (imem_ack) begin
                    state_d = (halt_pend_q || stop) ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (misalign && (state_q != S_HALT)) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            halt_pend_q  <= 1'b0;
            fault_q      <= 1'b0;
            drain_addr_q <= '0;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            halt_pend_q  <= halt_pend_d;
            fault_q      <= fault_d;
            drain_addr_q <= drain_addr_d;
            if (capture) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

    assign imem_req    = !reset && ((state_q == S_REQ) || (state_q == S_DRAIN));
    assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc;
    assign instr_valid = (state_q == S_HOLD);
    assign instruction = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scripted vector table, hand-written corner sequences and a
// randomized run scored against a transaction-level model of the fetched stream.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_fault;

    int n_vec = 0;
    int n_bad = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ a[15:0] ^ 16'h0F0F};
    endfunction

    assign imem_rdata = memw(imem_addr);

    typedef struct {
        logic        rst, ack, rdy, rv;
        logic [31:0] rpc;
        logic        hlt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_ipc;
        logic [31:0] e_ins;
        logic        e_ff;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic ack, input logic rdy,
                                input logic rv, input logic [31:0] rpc, input logic hlt,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_val, input logic [31:0] e_ipc,
                                input logic [31:0] e_ins, input logic e_ff);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_ipc = e_ipc;
        v.e_ins = e_ins; v.e_ff = e_ff;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs mid-period and let combinational outputs settle.
    task automatic cyc(input logic rst, input logic ack, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic hlt);
        @(negedge clk);
        reset = rst; imem_ack = ack; instr_ready = rdy;
        redirect_valid = rv; redirect_pc = rpc; halt = hlt;
        #2;
    endtask

    vec_t tbl [36];

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] txn_addr;
        logic        busy;
        int          wait_n;
        int          n_del;
        logic        a;

        reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;

        tbl[0]  = mk(1,0,0,0,32'h0,0,        0,32'h0,  0,32'h0,  NOP,        0);
        tbl[1]  = mk(0,1,1,0,32'h0,0,        1,32'h0,  0,32'h0,  NOP,        0);
        tbl[2]  = mk(0,0,1,0,32'h0,0,        0,32'h0,  1,32'h0,  memw(0),    0);
        tbl[3]  = mk(0,1,1,0,32'h0,0,        1,32'h4,  0,32'h0,  memw(0),    0);
        tbl[4]  = mk(0,0,1,0,32'h0,0,        0,32'h0,  1,32'h4,  memw(4),    0);
        tbl[5]  = mk(0,0,0,0,32'h0,0,        1,32'h8,  0,32'h4,  memw(4),    0);
        tbl[6]  = mk(0,0,0,0,32'h0,0,        1,32'h8,  0,32'h4,  memw(4),    0);
        tbl[7]  = mk(0,0,0,0,32'h0,0,        1,32'h8,  0,32'h4,  memw(4),    0);
        tbl[8]  = mk(0,1,0,0,32'h0,0,        1,32'h8,  0,32'h4,  memw(4),    0);
        tbl[9]  = mk(0,0,0,0,32'h0,0,        0,32'h0,  1,32'h8,  memw(8),    0);
        tbl[10] = mk(0,0,0,0,32'h0,0,        0,32'h0,  1,32'h8,  memw(8),    0);
        tbl[11] = mk(0,0,0,0,32'h0,0,        0,32'h0,  1,32'h8,  memw(8),    0);
        tbl[12] = mk(0,0,0,0,32'h0,0,        0,32'h0,  1,32'h8,  memw(8),    0);
        tbl[13] = mk(0,0,0,0,32'h0,0,        0,32'h0,  1,32'h8,  memw(8),    0);
        tbl[14] = mk(0,0,1,0,32'h0,0,        0,32'h0,  1,32'h8,  memw(8),    0);
        tbl[15] = mk(0,0,0,1,32'h40,0,       1,32'hC,  0,32'h8,  memw(8),    0);
        tbl[16] = mk(0,0,0,0,32'h0,0,        1,32'hC,  0,32'h8,  memw(8),    0);
        tbl[17] = mk(0,1,0,0,32'h0,0,        1,32'hC,  0,32'h8,  memw(8),    0);
        tbl[18] = mk(0,1,1,0,32'h0,0,        1,32'h40, 0,32'h8,  memw(8),    0);
        tbl[19] = mk(0,0,1,0,32'h0,0,        0,32'h0,  1,32'h40, memw(32'h40), 0);
        tbl[20] = mk(0,1,1,0,32'h0,0,        1,32'h44, 0,32'h40, memw(32'h40), 0);
        tbl[21] = mk(0,0,1,1,32'h80,0,       0,32'h0,  1,32'h44, memw(32'h44), 0);
        tbl[22] = mk(0,1,0,1,32'h100,0,      1,32'h80, 0,32'h44, memw(32'h44), 0);
        tbl[23] = mk(0,1,0,0,32'h0,0,        1,32'h100,0,32'h44, memw(32'h44), 0);
        tbl[24] = mk(0,0,1,0,32'h0,0,        0,32'h0,  1,32'h100,memw(32'h100),0);
        tbl[25] = mk(0,0,0,1,32'h42,0,       1,32'h104,0,32'h100,memw(32'h100),0);
        tbl[26] = mk(0,0,0,0,32'h0,0,        1,32'h104,0,32'h100,memw(32'h100),1);
        tbl[27] = mk(0,1,0,0,32'h0,0,        1,32'h104,0,32'h100,memw(32'h100),1);
        tbl[28] = mk(0,0,1,0,32'h0,0,        0,32'h0,  0,32'h100,memw(32'h100),1);
        tbl[29] = mk(0,0,0,1,32'h200,0,      0,32'h0,  0,32'h100,memw(32'h100),1);
        tbl[30] = mk(1,0,0,0,32'h0,0,        0,32'h0,  0,32'h100,memw(32'h100),1);
        tbl[31] = mk(0,1,0,0,32'h0,0,        1,32'h0,  0,32'h0,  NOP,        0);
        tbl[32] = mk(0,0,0,0,32'h0,1,        0,32'h0,  1,32'h0,  memw(0),    0);
        tbl[33] = mk(0,0,0,0,32'h0,0,        0,32'h0,  0,32'h0,  memw(0),    0);
        tbl[34] = mk(1,0,0,0,32'h0,0,        0,32'h0,  0,32'h0,  memw(0),    0);
        tbl[35] = mk(0,1,1,0,32'h0,0,        1,32'h0,  0,32'h0,  NOP,        0);

        cyc(1, 0, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 0, 32'h0, 0);

        for (int i = 0; i < 36; i++) begin
            cyc(tbl[i].rst, tbl[i].ack, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, tbl[i].hlt);
            chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_val});
            chk($sformatf("tbl%0d_ipc", i), instr_pc, tbl[i].e_ipc);
            chk($sformatf("tbl%0d_instr", i), instruction, tbl[i].e_ins);
            chk($sformatf("tbl%0d_fault", i), {31'b0, fetch_fault}, {31'b0, tbl[i].e_ff});
        end

        // Halt while a request is waiting: it drains at the old address, then fetch stops.
        cyc(0, 0, 1, 0, 32'h0, 0);
        chk("hreq_valid0", {31'b0, instr_valid}, 32'd1);
        cyc(0, 0, 0, 0, 32'h0, 1);
        chk("hreq_addr", imem_addr, 32'h4);
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("hreq_drain_req", {31'b0, imem_req}, 32'd1);
        chk("hreq_drain_addr", imem_addr, 32'h4);
        cyc(0, 1, 0, 0, 32'h0, 0);
        chk("hreq_drain_valid", {31'b0, instr_valid}, 32'd0);
        cyc(0, 0, 1, 0, 32'h0, 0);
        chk("hreq_halt_req", {31'b0, imem_req}, 32'd0);
        chk("hreq_halt_valid", {31'b0, instr_valid}, 32'd0);
        chk("hreq_ipc", instr_pc, 32'h0);

        // Misaligned redirect while holding goes straight to halt with a fault.
        cyc(1, 0, 0, 0, 32'h0, 0);
        cyc(0, 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 32'h43, 0);
        cyc(0, 0, 1, 0, 32'h0, 0);
        chk("mis_hold_fault", {31'b0, fetch_fault}, 32'd1);
        chk("mis_hold_req", {31'b0, imem_req}, 32'd0);
        chk("mis_hold_valid", {31'b0, instr_valid}, 32'd0);

        // Halt and redirect together: halt wins.
        cyc(1, 0, 0, 0, 32'h0, 0);
        cyc(0, 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 1, 1, 32'h80, 1);
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("hr_req", {31'b0, imem_req}, 32'd0);
        chk("hr_valid", {31'b0, instr_valid}, 32'd0);
        chk("hr_fault", {31'b0, fetch_fault}, 32'd0);

        // Redirect to the top word; the sequential PC must wrap to zero.
        cyc(1, 0, 0, 0, 32'h0, 0);
        cyc(0, 1, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 1, 0, 0, 32'h0, 0);
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 1, 0, 32'h0, 0);
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instruction, memw(32'hFFFF_FFFC));
        cyc(0, 0, 0, 0, 32'h0, 0);
        chk("wrap_addr_zero", imem_addr, 32'h0);

        // Randomized run: the delivered stream must follow pc+4 except after redirects.
        cyc(1, 0, 0, 0, 32'h0, 0);
        exp_pc = 32'h0;
        busy   = 1'b0;
        wait_n = 0;
        n_del  = 0;
        txn_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = 1'b0;
            halt  = 1'b0;
            a     = 1'b0;
            if (imem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    wait_n   = $urandom_range(0, 3);
                    txn_addr = exp_pc;
                end
                chk("rnd_addr", imem_addr, txn_addr);
                if (wait_n == 0) begin
                    a    = 1'b1;
                    busy = 1'b0;
                end else begin
                    wait_n--;
                end
            end
            imem_ack       = a;
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                                                         : (32'($urandom_range(0, 4095)) << 2);
            #2;
            if (instr_valid) chk("rnd_no_req_in_hold", {31'b0, imem_req}, 32'd0);
            if (instr_valid && instr_ready && !redirect_valid) begin
                chk("rnd_ipc", instr_pc, exp_pc);
                chk("rnd_instr", instruction, memw(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_del++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
        end
        chk("rnd_progress", {31'b0, (n_del >= 200)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
